// File: rtl/alu_seq_if.sv
// Operand/opcode/handshake bundle between the Nibbler datapath and alu_seq.
// The master drives start, opcode and operands. The slave returns the result, the flags and the handshake.
interface alu_seq_if #(parameter int N = 4);
  logic         start;
  logic [4:0]   S;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         nCin;
  logic         ready;
  logic         done;
  logic [N-1:0] Result;
  logic [N-1:0] ResultHi;
  logic         Cout;
  logic         eq;
  logic         neg;
  logic         ovf;

  modport master (
    output start, S, A, B, nCin,
    input  ready, done, Result, ResultHi, Cout, eq, neg, ovf
  );

  modport slave (
    input  start, S, A, B, nCin,
    output ready, done, Result, ResultHi, Cout, eq, neg, ovf
  );
endinterface

// File: rtl/alu_seq.sv
// Registered N-bit ALU with stored flags, carry chaining and a shift-add multiplier.
// Single-cycle ops complete from IDLE. MUL runs N iterations in MUL_RUN.
module alu_seq #(
  parameter int N = 4
) (
  input  logic       clk,
  input  logic       reset,
  alu_seq_if.slave   bus
);
  localparam int CW = $clog2(N);

  localparam logic [4:0] OP_PASSA = 5'b00000;
  localparam logic [4:0] OP_PASSB = 5'b11010;
  localparam logic [4:0] OP_ADD   = 5'b01001;
  localparam logic [4:0] OP_ADC   = 5'b01011;
  localparam logic [4:0] OP_SUB   = 5'b00110;
  localparam logic [4:0] OP_SBB   = 5'b00111;
  localparam logic [4:0] OP_NOR   = 5'b10001;
  localparam logic [4:0] OP_SHL   = 5'b01100;
  localparam logic [4:0] OP_SHR   = 5'b01101;
  localparam logic [4:0] OP_MUL   = 5'b11100;

  typedef enum logic {IDLE, MUL_RUN} state_t;

  state_t         state_reg, state_next;
  logic [N-1:0]   result_reg, result_next;
  logic [N-1:0]   resulthi_reg, resulthi_next;
  logic           cout_reg, cout_next;
  logic           eq_reg, eq_next;
  logic           neg_reg, neg_next;
  logic           ovf_reg, ovf_next;
  logic           done_reg, done_next;
  logic [N-1:0]   mcand_reg, mcand_next;
  logic [2*N-1:0] prod_reg, prod_next;
  logic [CW-1:0]  count_reg, count_next;

  logic [N:0]     add_ext, sub_ext, mul_sum;
  logic           add_cin, sub_bin, add_ovf, sub_ovf;
  logic [2*N-1:0] prod_step;
  logic [N-1:0]   sc_res;
  logic           sc_cout, sc_ovf;

  // Carry/borrow-in for the chained forms is the flag as it stands when start is accepted.
  assign add_cin = (bus.S == OP_ADC) ? cout_reg : ~bus.nCin;
  assign sub_bin = (bus.S == OP_SBB) ? cout_reg : 1'b0;
  assign add_ext = {1'b0, bus.A} + {1'b0, bus.B} + {{N{1'b0}}, add_cin};
  assign sub_ext = {1'b0, bus.A} - {1'b0, bus.B} - {{N{1'b0}}, sub_bin};
  assign add_ovf = (bus.A[N-1] == bus.B[N-1]) && (add_ext[N-1] != bus.A[N-1]);
  assign sub_ovf = (bus.A[N-1] != bus.B[N-1]) && (sub_ext[N-1] != bus.A[N-1]);

  // The high half of prod_reg accumulates while the multiplier shifts out of the low half.
  assign mul_sum   = {1'b0, prod_reg[2*N-1:N]} + (prod_reg[0] ? {1'b0, mcand_reg} : {(N+1){1'b0}});
  assign prod_step = {mul_sum, prod_reg[N-1:1]};

  always_comb begin
    sc_res  = '0;
    sc_cout = 1'b0;
    sc_ovf  = 1'b0;
    case (bus.S)
      OP_PASSA: sc_res = bus.A;
      OP_PASSB: sc_res = bus.B;
      OP_ADD, OP_ADC: begin
        {sc_cout, sc_res} = add_ext;
        sc_ovf = add_ovf;
      end
      OP_SUB, OP_SBB: begin
        {sc_cout, sc_res} = sub_ext;
        sc_ovf = sub_ovf;
      end
      OP_NOR: sc_res = ~(bus.A | bus.B);
      OP_SHL: begin
        sc_res  = {bus.A[N-2:0], 1'b0};
        sc_cout = bus.A[N-1];
      end
      OP_SHR: begin
        sc_res  = {1'b0, bus.A[N-1:1]};
        sc_cout = bus.A[0];
      end
      default: sc_res = '0;
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    result_next   = result_reg;
    resulthi_next = resulthi_reg;
    cout_next     = cout_reg;
    eq_next       = eq_reg;
    neg_next      = neg_reg;
    ovf_next      = ovf_reg;
    done_next     = 1'b0;
    mcand_next    = mcand_reg;
    prod_next     = prod_reg;
    count_next    = count_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          if (bus.S == OP_MUL) begin
            state_next = MUL_RUN;
            mcand_next = bus.A;
            prod_next  = {{N{1'b0}}, bus.B};
            count_next = '0;
          end else begin
            done_next     = 1'b1;
            result_next   = sc_res;
            resulthi_next = '0;
            cout_next     = sc_cout;
            ovf_next      = sc_ovf;
            eq_next       = (sc_res == '0);
            neg_next      = sc_res[N-1];
          end
        end
      end
      MUL_RUN: begin
        prod_next  = prod_step;
        count_next = count_reg + CW'(1);
        if (count_reg == CW'(N-1)) begin
          state_next    = IDLE;
          done_next     = 1'b1;
          result_next   = prod_step[N-1:0];
          resulthi_next = prod_step[2*N-1:N];
          cout_next     = |prod_step[2*N-1:N];
          eq_next       = (prod_step == '0);
          neg_next      = prod_step[N-1];
          ovf_next      = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      result_reg   <= '0;
      resulthi_reg <= '0;
      cout_reg     <= 1'b0;
      eq_reg       <= 1'b0;
      neg_reg      <= 1'b0;
      ovf_reg      <= 1'b0;
      done_reg     <= 1'b0;
      mcand_reg    <= '0;
      prod_reg     <= '0;
      count_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      result_reg   <= result_next;
      resulthi_reg <= resulthi_next;
      cout_reg     <= cout_next;
      eq_reg       <= eq_next;
      neg_reg      <= neg_next;
      ovf_reg      <= ovf_next;
      done_reg     <= done_next;
      mcand_reg    <= mcand_next;
      prod_reg     <= prod_next;
      count_reg    <= count_next;
    end
  end

  assign bus.ready    = (state_reg == IDLE);
  assign bus.done     = done_reg;
  assign bus.Result   = result_reg;
  assign bus.ResultHi = resulthi_reg;
  assign bus.Cout     = cout_reg;
  assign bus.eq       = eq_reg;
  assign bus.neg      = neg_reg;
  assign bus.ovf      = ovf_reg;
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: runs a 4-bit and an 8-bit instance side by side against spec vectors,
// a signed/unsigned arithmetic reference model, and the reset-during-MUL sequence.
module tb_alu_seq;
  localparam logic [4:0] OP_PASSA = 5'b00000;
  localparam logic [4:0] OP_PASSB = 5'b11010;
  localparam logic [4:0] OP_ADD   = 5'b01001;
  localparam logic [4:0] OP_ADC   = 5'b01011;
  localparam logic [4:0] OP_SUB   = 5'b00110;
  localparam logic [4:0] OP_SBB   = 5'b00111;
  localparam logic [4:0] OP_NOR   = 5'b10001;
  localparam logic [4:0] OP_SHL   = 5'b01100;
  localparam logic [4:0] OP_SHR   = 5'b01101;
  localparam logic [4:0] OP_MUL   = 5'b11100;

  typedef struct {
    int res;
    int hi;
    int cout;
    int eq;
    int neg;
    int ovf;
  } flags_t;

  typedef struct {
    int         n;
    logic [4:0] s;
    int         a;
    int         b;
    bit         ncin;
    bit         poke;
    flags_t     e;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_seq_if #(.N(4)) b4();
  alu_seq_if #(.N(8)) b8();

  alu_seq #(.N(4)) dut4 (.clk(clk), .reset(reset), .bus(b4));
  alu_seq #(.N(8)) dut8 (.clk(clk), .reset(reset), .bus(b8));

  int n_checks = 0;
  int n_fail   = 0;
  int mcout[2];

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_flags(string tag, flags_t o, flags_t e);
    check({tag, ".Result"},   o.res,  e.res);
    check({tag, ".ResultHi"}, o.hi,   e.hi);
    check({tag, ".Cout"},     o.cout, e.cout);
    check({tag, ".eq"},       o.eq,   e.eq);
    check({tag, ".neg"},      o.neg,  e.neg);
    check({tag, ".ovf"},      o.ovf,  e.ovf);
  endtask

  // Reference: plain integer arithmetic, with signed overflow judged by range.
  function automatic flags_t model(int n, logic [4:0] s, int a, int b, bit ncin, int cin);
    flags_t f;
    int mask = (1 << n) - 1;
    int half = 1 << (n - 1);
    int sa   = (a >= half) ? a - (1 << n) : a;
    int sb   = (b >= half) ? b - (1 << n) : b;
    int c;
    int t;
    f = '{default: 0};
    case (s)
      OP_PASSA: f.res = a;
      OP_PASSB: f.res = b;
      OP_ADD, OP_ADC: begin
        c = (s == OP_ADD) ? (ncin ? 0 : 1) : cin;
        t = a + b + c;
        f.res  = t & mask;
        f.cout = (t > mask) ? 1 : 0;
        t = sa + sb + c;
        f.ovf  = (t > half - 1 || t < -half) ? 1 : 0;
      end
      OP_SUB, OP_SBB: begin
        c = (s == OP_SUB) ? 0 : cin;
        t = a - b - c;
        f.res  = t & mask;
        f.cout = (t < 0) ? 1 : 0;
        t = sa - sb - c;
        f.ovf  = (t > half - 1 || t < -half) ? 1 : 0;
      end
      OP_NOR: f.res = ~(a | b) & mask;
      OP_SHL: begin
        f.res  = (a << 1) & mask;
        f.cout = (a >> (n - 1)) & 1;
      end
      OP_SHR: begin
        f.res  = a >> 1;
        f.cout = a & 1;
      end
      OP_MUL: begin
        t = a * b;
        f.res  = t & mask;
        f.hi   = t >> n;
        f.cout = (f.hi != 0) ? 1 : 0;
      end
      default: f.res = 0;
    endcase
    if (s == OP_MUL) f.eq = (a * b == 0) ? 1 : 0;
    else             f.eq = (f.res == 0) ? 1 : 0;
    f.neg = (f.res >> (n - 1)) & 1;
    return f;
  endfunction

  task automatic set_in(int n, bit st, logic [4:0] s, int a, int b, bit nc);
    if (n == 4) begin
      b4.start = st; b4.S = s; b4.A = a[3:0]; b4.B = b[3:0]; b4.nCin = nc;
    end else begin
      b8.start = st; b8.S = s; b8.A = a[7:0]; b8.B = b[7:0]; b8.nCin = nc;
    end
  endtask

  task automatic get_out(int n, output flags_t o, output bit rdy, output bit dn);
    if (n == 4) begin
      o.res = int'(b4.Result); o.hi = int'(b4.ResultHi); o.cout = int'(b4.Cout);
      o.eq = int'(b4.eq); o.neg = int'(b4.neg); o.ovf = int'(b4.ovf);
      rdy = b4.ready; dn = b4.done;
    end else begin
      o.res = int'(b8.Result); o.hi = int'(b8.ResultHi); o.cout = int'(b8.Cout);
      o.eq = int'(b8.eq); o.neg = int'(b8.neg); o.ovf = int'(b8.ovf);
      rdy = b8.ready; dn = b8.done;
    end
  endtask

  // Called just after a falling edge; returns the outputs seen in the done cycle.
  task automatic run_op(string tag, int n, logic [4:0] s, int a, int b, bit nc, bit poke,
                        output flags_t o);
    bit rdy, dn;
    int lat = 1;
    int lowcnt = 0;
    int exp_lat = (s == OP_MUL) ? n + 1 : 1;
    set_in(n, 1'b1, s, a, b, nc);
    @(negedge clk);
    set_in(n, 1'b0, s, int'($urandom), int'($urandom), nc);
    get_out(n, o, rdy, dn);
    while (!dn && lat < 4 * n + 8) begin
      if (!rdy) lowcnt++;
      set_in(n, (poke && lat == 2), OP_ADD, 1, 1, 1'b1);
      @(negedge clk);
      lat++;
      get_out(n, o, rdy, dn);
    end
    set_in(n, 1'b0, OP_ADD, 0, 0, 1'b1);
    check({tag, ".done_seen"}, int'(dn), 1);
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".ready_low_cycles"}, lowcnt, (s == OP_MUL) ? n : 0);
    check({tag, ".ready_at_done"}, int'(rdy), 1);
    @(negedge clk);
    begin
      flags_t tmp;
      get_out(n, tmp, rdy, dn);
      check({tag, ".done_single_pulse"}, int'(dn), 0);
    end
  endtask

  vec_t tbl[$];
  logic [4:0] ops[12] = '{OP_PASSA, OP_PASSB, OP_ADD, OP_ADC, OP_SUB, OP_SBB,
                          OP_NOR, OP_SHL, OP_SHR, OP_MUL, 5'b11111, 5'b00001};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    flags_t o, e, zero;
    bit rdy, dn;
    zero = '{default: 0};

    tbl.push_back('{4, OP_ADD,   9,   8,   1'b1, 1'b0, '{1, 0, 1, 0, 0, 1}});
    tbl.push_back('{4, OP_ADD,   7,   8,   1'b0, 1'b0, '{0, 0, 1, 1, 0, 0}});
    tbl.push_back('{4, OP_ADD,   12,  7,   1'b1, 1'b0, '{3, 0, 1, 0, 0, 0}});
    tbl.push_back('{4, OP_ADC,   3,   4,   1'b1, 1'b0, '{8, 0, 0, 0, 1, 1}});
    tbl.push_back('{4, OP_SUB,   3,   5,   1'b1, 1'b0, '{14, 0, 1, 0, 1, 0}});
    tbl.push_back('{4, OP_SBB,   0,   0,   1'b1, 1'b0, '{15, 0, 1, 0, 1, 0}});
    tbl.push_back('{4, OP_SUB,   5,   5,   1'b1, 1'b0, '{0, 0, 0, 1, 0, 0}});
    tbl.push_back('{4, OP_MUL,   15,  15,  1'b1, 1'b1, '{1, 14, 1, 0, 0, 0}});
    tbl.push_back('{4, OP_MUL,   0,   9,   1'b1, 1'b0, '{0, 0, 0, 1, 0, 0}});
    tbl.push_back('{4, OP_NOR,   10,  5,   1'b1, 1'b0, '{0, 0, 0, 1, 0, 0}});
    tbl.push_back('{4, OP_SHL,   9,   0,   1'b1, 1'b0, '{2, 0, 1, 0, 0, 0}});
    tbl.push_back('{4, OP_SHR,   3,   0,   1'b1, 1'b0, '{1, 0, 1, 0, 0, 0}});
    tbl.push_back('{4, 5'b11111, 6,   6,   1'b1, 1'b0, '{0, 0, 0, 1, 0, 0}});
    tbl.push_back('{4, OP_PASSA, 11,  2,   1'b1, 1'b0, '{11, 0, 0, 0, 1, 0}});
    tbl.push_back('{4, OP_PASSB, 0,   6,   1'b1, 1'b0, '{6, 0, 0, 0, 0, 0}});
    tbl.push_back('{8, OP_ADD,   9,   8,   1'b1, 1'b0, '{17, 0, 0, 0, 0, 0}});
    tbl.push_back('{8, OP_ADD,   7,   8,   1'b0, 1'b0, '{16, 0, 0, 0, 0, 0}});
    tbl.push_back('{8, OP_ADD,   128, 128, 1'b1, 1'b0, '{0, 0, 1, 1, 0, 1}});
    tbl.push_back('{8, OP_MUL,   255, 255, 1'b1, 1'b1, '{1, 254, 1, 0, 0, 0}});
    tbl.push_back('{8, OP_MUL,   0,   9,   1'b1, 1'b0, '{0, 0, 0, 1, 0, 0}});

    reset = 1'b1;
    set_in(4, 1'b0, OP_PASSA, 0, 0, 1'b1);
    set_in(8, 1'b0, OP_PASSA, 0, 0, 1'b1);
    repeat (2) @(negedge clk);
    get_out(4, o, rdy, dn);
    check_flags("reset4", o, zero);
    check("reset4.ready", int'(rdy), 1);
    check("reset4.done", int'(dn), 0);
    get_out(8, o, rdy, dn);
    check_flags("reset8", o, zero);
    reset = 1'b0;
    mcout[0] = 0;
    mcout[1] = 0;
    @(negedge clk);

    foreach (tbl[i]) begin
      run_op($sformatf("vec%0d", i), tbl[i].n, tbl[i].s, tbl[i].a, tbl[i].b,
             tbl[i].ncin, tbl[i].poke, o);
      check_flags($sformatf("vec%0d", i), o, tbl[i].e);
      mcout[(tbl[i].n == 4) ? 0 : 1] = tbl[i].e.cout;
      $display("vec%0d n=%0d S=%05b A=%0h B=%0h -> Result=%0h Hi=%0h Cout=%0d eq=%0d",
               i, tbl[i].n, tbl[i].s, tbl[i].a, tbl[i].b, o.res, o.hi, o.cout, o.eq);
    end

    // Back-to-back nibble chain 0x3C + 0x47 with start held for two cycles.
    set_in(4, 1'b1, OP_ADD, 12, 7, 1'b1);
    @(negedge clk);
    get_out(4, o, rdy, dn);
    check("chain.lo.done", int'(dn), 1);
    check("chain.lo.Result", o.res, 3);
    check("chain.lo.Cout", o.cout, 1);
    set_in(4, 1'b1, OP_ADC, 3, 4, 1'b1);
    @(negedge clk);
    get_out(4, o, rdy, dn);
    check("chain.hi.done", int'(dn), 1);
    check("chain.hi.Result", o.res, 8);
    check("chain.hi.Cout", o.cout, 0);
    set_in(4, 1'b0, OP_PASSA, 0, 0, 1'b1);
    repeat (2) @(negedge clk);
    get_out(4, o, rdy, dn);
    check("hold.done", int'(dn), 0);
    check("hold.Result", o.res, 8);
    mcout[0] = 0;
    $display("chain 0x3C+0x47 -> hi=%0h", o.res);

    for (int i = 0; i < 160; i++) begin
      int n = (i % 2 == 0) ? 4 : 8;
      int idx = (n == 4) ? 0 : 1;
      int mask = (1 << n) - 1;
      logic [4:0] s = ops[$urandom_range(0, 11)];
      int a = int'($urandom) & mask;
      int b = int'($urandom) & mask;
      bit nc = 1'($urandom_range(0, 1));
      e = model(n, s, a, b, nc, mcout[idx]);
      run_op($sformatf("rnd%0d", i), n, s, a, b, nc, 1'b0, o);
      check_flags($sformatf("rnd%0d", i), o, e);
      mcout[idx] = e.cout;
      $display("rnd%0d n=%0d S=%05b A=%0h B=%0h -> Result=%0h Hi=%0h Cout=%0d ovf=%0d",
               i, n, s, a, b, o.res, o.hi, o.cout, o.ovf);
    end

    // Asynchronous reset two cycles into a MUL.
    run_op("prerst", 4, OP_ADD, 9, 8, 1'b1, 1'b0, o);
    check("prerst.Result", o.res, 1);
    set_in(4, 1'b1, OP_MUL, 15, 15, 1'b1);
    @(negedge clk);
    set_in(4, 1'b0, OP_PASSA, 0, 0, 1'b1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 get_out(4, o, rdy, dn);
    check_flags("rst_async", o, zero);
    check("rst_async.ready", int'(rdy), 1);
    check("rst_async.done", int'(dn), 0);
    @(negedge clk);
    reset = 1'b0;
    mcout[0] = 0;
    mcout[1] = 0;
    begin
      int dones = 0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        get_out(4, o, rdy, dn);
        if (dn) dones++;
      end
      check("rst_abort.no_done", dones, 0);
      check("rst_abort.ready", int'(rdy), 1);
    end
    run_op("postrst", 4, OP_ADD, 9, 8, 1'b1, 1'b0, o);
    check_flags("postrst", o, '{1, 0, 1, 0, 0, 1});
    $display("reset-during-MUL sequence -> post ADD Result=%0h", o.res);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
